// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and defaults for the packet-aware round-robin stream arbiter.
package stream_rr_arbiter_pkg;

   localparam int DEFAULT_DW = 8;
   localparam int DEFAULT_N  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req after ptr, wrapping modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [SW-1:0] gnt_idx,
   output logic          gnt_any
);

   logic [SW-1:0] cand;

   // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      // N is a power of two, so SW-bit addition wraps modulo N for free.
      for (int i = 1; i <= N; i++) begin
         cand = ptr + SW'(i);
         if (!gnt_any && req[cand]) begin
            gnt_idx = cand;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 stream arbiter: round-robin between packets, locked to one owner until its last beat.
module stream_rr_arbiter
   import stream_rr_arbiter_pkg::*;
#(
   parameter int DW = DEFAULT_DW,
   parameter int N  = DEFAULT_N,
   localparam int SW = $clog2(N)
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic [N-1:0]    i_valid,
   input  logic [N*DW-1:0] i_data,
   input  logic [N-1:0]    i_last,
   output logic [N-1:0]    o_ready,
   output logic            o_valid,
   output logic [DW-1:0]   o_data,
   output logic            o_last,
   output logic [SW-1:0]   o_src,
   input  logic            i_ready
);

   state_t        state, state_nx;
   logic [SW-1:0] owner;
   logic [SW-1:0] ptr;
   logic [SW-1:0] pick_idx;
   logic          pick_any;
   logic [SW-1:0] sel;
   logic          sel_any;
   logic          load;
   logic          xfer;

   rr_pick #(.N(N), .SW(SW)) u_pick (
      .req     (i_valid),
      .ptr     (ptr),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   // While locked the owner keeps the grant even when it idles, so packets never interleave.
   assign sel     = (state == LOCK) ? owner : pick_idx;
   assign sel_any = (state == LOCK) ? 1'b1  : pick_any;
   assign load    = !o_valid || i_ready;
   assign xfer    = i_reset_n && load && sel_any && i_valid[sel];

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= SW'(N - 1);
      end else begin
         state <= state_nx;
         if (xfer && state == IDLE && !i_last[sel])
            owner <= sel;
         if (xfer && i_last[sel])
            ptr <= sel;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (xfer && !i_last[sel]) state_nx = LOCK;
         LOCK:    if (xfer &&  i_last[sel]) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      o_ready = '0;
      if (i_reset_n && load && sel_any)
         o_ready[sel] = 1'b1;
   end

   // Output beat register: payload only changes on a transfer, valid drops on an empty load.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_last  <= 1'b0;
         o_src   <= '0;
      end else if (load) begin
         o_valid <= xfer;
         if (xfer) begin
            o_data <= i_data[sel*DW +: DW];
            o_last <= i_last[sel];
            o_src  <= sel;
         end
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter (DW=8, N=4).
module tb_stream_rr_arbiter;
   import stream_rr_arbiter_pkg::*;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int SW = 2;

   logic            i_clk;
   logic            i_reset_n;
   logic [N-1:0]    i_valid;
   logic [N*DW-1:0] i_data;
   logic [N-1:0]    i_last;
   logic [N-1:0]    o_ready;
   logic            o_valid;
   logic [DW-1:0]   o_data;
   logic            o_last;
   logic [SW-1:0]   o_src;
   logic            i_ready;

   int checks = 0;
   int errors = 0;

   stream_rr_arbiter #(.DW(DW), .N(N)) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .i_last    (i_last),
      .o_ready   (o_ready),
      .o_valid   (o_valid),
      .o_data    (o_data),
      .o_last    (o_last),
      .o_src     (o_src),
      .i_ready   (i_ready)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Advance one rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_data(input int k, input logic [DW-1:0] v);
      i_data[k*DW +: DW] = v;
   endtask

   task automatic do_reset();
      i_reset_n = 1'b0;
      i_valid   = '0;
      i_last    = '0;
      i_ready   = 1'b1;
      i_data    = '0;
      tick();
      tick();
      i_reset_n = 1'b1;
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0;
      i_valid   = 4'b1111;
      i_last    = 4'b1111;
      i_ready   = 1'b1;
      i_data    = 32'hDDCC_BBAA;
      #1;
      checks++;
      if (o_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready got=%b exp=0000", o_ready);
      end
      tick();
      tick();
      checks++;
      if ({o_valid, o_data, o_last, o_src} !== {1'b0, 8'h00, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL reset_outputs got v=%b d=%h l=%b s=%0d exp all zero", o_valid, o_data, o_last, o_src);
      end
      checks++;
      if (dut.state !== IDLE) begin
         errors++;
         $display("FAIL reset_state got=%0d exp=IDLE", dut.state);
      end
      i_reset_n = 1'b1;
   endtask

   // Requesters 0 and 2 with single-beat packets alternate 0,2,0,2.
   task automatic test_two_req_alternate();
      logic [SW-1:0] exp_src [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
      do_reset();
      set_data(0, 8'hA0);
      set_data(2, 8'hC2);
      i_valid = 4'b0101;
      i_last  = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (o_valid !== 1'b1 || o_src !== exp_src[c] || o_last !== 1'b1 ||
             o_data !== (exp_src[c] == 2'd0 ? 8'hA0 : 8'hC2)) begin
            errors++;
            $display("FAIL alternate_c%0d got v=%b s=%0d d=%h exp v=1 s=%0d", c, o_valid, o_src, o_data, exp_src[c]);
         end
      end
   endtask

   // 3-beat packet from requester 1 is not interleaved by valid requester 3.
   task automatic test_packet_lock();
      logic [DW-1:0] beats [3] = '{8'h11, 8'h12, 8'h13};
      do_reset();
      i_valid = 4'b1010;
      set_data(3, 8'h33);
      i_last = 4'b1000;
      for (int b = 0; b < 3; b++) begin
         set_data(1, beats[b]);
         i_last[1] = (b == 2);
         #1;
         checks++;
         if (o_ready !== 4'b0010) begin
            errors++;
            $display("FAIL lock_ready_b%0d got=%b exp=0010", b, o_ready);
         end
         tick();
         checks++;
         if (o_valid !== 1'b1 || o_data !== beats[b] || o_src !== 2'd1 || o_last !== (b == 2)) begin
            errors++;
            $display("FAIL lock_beat%0d got v=%b d=%h s=%0d l=%b exp d=%h s=1", b, o_valid, o_data, o_src, o_last, beats[b]);
         end
      end
      i_valid = 4'b1000;
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h33 || o_src !== 2'd3) begin
         errors++;
         $display("FAIL lock_next_req got v=%b d=%h s=%0d exp v=1 d=33 s=3", o_valid, o_data, o_src);
      end
   endtask

   // Downstream stall holds the beat and blocks all requesters.
   task automatic test_backpressure();
      do_reset();
      i_valid = 4'b0001;
      i_last  = 4'b0001;
      set_data(0, 8'hA5);
      tick();
      set_data(0, 8'h5A);
      i_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (o_ready !== 4'b0000) begin
            errors++;
            $display("FAIL stall_ready_c%0d got=%b exp=0000", c, o_ready);
         end
         tick();
         checks++;
         if (o_valid !== 1'b1 || o_data !== 8'hA5) begin
            errors++;
            $display("FAIL stall_hold_c%0d got v=%b d=%h exp v=1 d=a5", c, o_valid, o_data);
         end
      end
      i_ready = 1'b1;
      #1;
      checks++;
      if (o_ready !== 4'b0001) begin
         errors++;
         $display("FAIL stall_release_ready got=%b exp=0001", o_ready);
      end
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h5A || o_src !== 2'd0) begin
         errors++;
         $display("FAIL stall_release_beat got v=%b d=%h s=%0d exp v=1 d=5a s=0", o_valid, o_data, o_src);
      end
   endtask

   // Owner 2 idles mid-packet: bubbles, no grant to requester 0, then resumes.
   task automatic test_owner_bubble();
      do_reset();
      i_valid = 4'b0100;
      i_last  = 4'b0001;
      set_data(2, 8'h21);
      set_data(0, 8'h0F);
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h21 || o_src !== 2'd2) begin
         errors++;
         $display("FAIL bubble_first got v=%b d=%h s=%0d exp v=1 d=21 s=2", o_valid, o_data, o_src);
      end
      i_valid = 4'b0001;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (o_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bubble_ready0_c%0d got=%b exp=0", c, o_ready[0]);
         end
         tick();
         checks++;
         if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_valid_c%0d got=%b exp=0", c, o_valid);
         end
      end
      i_valid = 4'b0101;
      set_data(2, 8'h22);
      i_last[2] = 1'b1;
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h22 || o_src !== 2'd2 || o_last !== 1'b1) begin
         errors++;
         $display("FAIL bubble_resume got v=%b d=%h s=%0d l=%b exp v=1 d=22 s=2 l=1", o_valid, o_data, o_src, o_last);
      end
      i_valid = 4'b0001;
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h0F || o_src !== 2'd0) begin
         errors++;
         $display("FAIL bubble_after got v=%b d=%h s=%0d exp v=1 d=0f s=0", o_valid, o_data, o_src);
      end
   endtask

   // Reset during beat 2 of a 4-beat packet drops the lock and the held beat.
   task automatic test_mid_packet_reset();
      do_reset();
      i_valid = 4'b0001;
      i_last  = 4'b0000;
      set_data(0, 8'h40);
      tick();
      set_data(0, 8'h41);
      i_reset_n = 1'b0;
      #1;
      checks++;
      if (o_ready !== 4'b0000) begin
         errors++;
         $display("FAIL midrst_ready got=%b exp=0000", o_ready);
      end
      tick();
      checks++;
      if (o_valid !== 1'b0 || o_data !== 8'h00 || dut.state !== IDLE) begin
         errors++;
         $display("FAIL midrst_state got v=%b d=%h st=%0d exp v=0 d=00 IDLE", o_valid, o_data, dut.state);
      end
      i_reset_n = 1'b1;
      i_valid = 4'b1111;
      i_last  = 4'b1111;
      i_data  = 32'h8382_8180;
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_src !== 2'd0 || o_data !== 8'h80) begin
         errors++;
         $display("FAIL midrst_first got v=%b s=%0d d=%h exp v=1 s=0 d=80", o_valid, o_src, o_data);
      end
   endtask

   // All four valid with single-beat packets: fair order 0,1,2,3,0.
   task automatic test_back_to_back();
      logic [SW-1:0] exp_src [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      i_valid = 4'b1111;
      i_last  = 4'b1111;
      i_data  = 32'hD3C2_B1A0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (o_valid !== 1'b1 || o_src !== exp_src[c]) begin
            errors++;
            $display("FAIL rr_order_c%0d got v=%b s=%0d exp v=1 s=%0d", c, o_valid, o_src, exp_src[c]);
         end
      end
      checks++;
      if (o_data !== 8'hA0) begin
         errors++;
         $display("FAIL rr_data got=%h exp=a0", o_data);
      end
   endtask

   initial begin
      i_reset_n = 1'b0;
      i_valid   = '0;
      i_last    = '0;
      i_data    = '0;
      i_ready   = 1'b1;
      test_reset();
      test_two_req_alternate();
      test_packet_lock();
      test_backpressure();
      test_owner_bubble();
      test_mid_packet_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the data width per beat.
REQ-002 The block SHALL have parameter N, default 4, meaning the number of requesters (N >= 2, power of two); SW = log2(N).
REQ-003 Port i_clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port i_reset_n SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-005 Port i_valid SHALL be an input, N bits: per-requester beat valid.
REQ-006 Port i_data SHALL be an input, N*DW bits: requester k's data occupies bits [k*DW +: DW].
REQ-007 Port i_last SHALL be an input, N bits: per-requester last-beat-of-packet flag.
REQ-008 Port o_ready SHALL be an output, N bits: per-requester ready.
REQ-009 Port o_valid SHALL be an output, 1 bit: registered downstream valid.
REQ-010 Port o_data SHALL be an output, DW bits: registered downstream data.
REQ-011 Port o_last SHALL be an output, 1 bit: registered downstream last.
REQ-012 Port o_src SHALL be an output, SW bits: registered index of the requester that supplied the current output beat.
REQ-013 Port i_ready SHALL be an input, 1 bit: downstream ready.

Function
REQ-014 load SHALL be defined as (!o_valid || i_ready); output registers update only when load=1 and otherwise hold.
REQ-015 The FSM SHALL have exactly two states, IDLE (no owner) and LOCK (owner register valid).
REQ-016 In IDLE, sel SHALL be the first requester k with i_valid[k]=1, searching in order ptr+1, ptr+2, ... modulo N; if none is valid, there is no selection.
REQ-017 In LOCK, sel SHALL be the owner, regardless of the other i_valid bits.
REQ-018 o_ready[k] SHALL equal load && (k==sel) && (a selection exists); this is combinational, and at most one bit is high.
REQ-019 A transfer on requester k SHALL occur when i_valid[k] && o_ready[k].
REQ-020 On a transfer, o_valid, o_data, o_last and o_src SHALL take 1, i_data[k], i_last[k] and k the next cycle, giving a latency of 1 cycle.
REQ-021 When load=1 and no transfer occurs, o_valid SHALL become 0 while o_data, o_last and o_src hold.
REQ-022 On a transfer in IDLE with i_last[k]=0, the FSM SHALL go to LOCK with owner=k.
REQ-023 On a transfer in IDLE with i_last[k]=1 (a single-beat packet), the FSM SHALL stay in IDLE.
REQ-024 On the transfer of the last beat in LOCK, the FSM SHALL return to IDLE.
REQ-025 ptr SHALL be set to k on every transfer completing a packet (i_last[k]=1), and SHALL otherwise hold.
REQ-026 If the owner deasserts i_valid in LOCK, the output SHALL bubble (o_valid=0 after load), and there SHALL be no re-arbitration and no grant to others.
REQ-027 When i_ready=0 and o_valid=1, all o_ready bits SHALL be 0 and the output beat SHALL be held stable.
REQ-028 Packets from different requesters SHALL never interleave at the output.

Reset
REQ-029 While i_reset_n=0 at a clock edge, the block SHALL set o_valid=0, o_data=0, o_last=0, o_src=0, state=IDLE, owner=0 and ptr=N-1, so that requester 0 wins first.
REQ-030 A reset mid-packet SHALL drop the lock, discard the held output beat, and require no partial-packet recovery.
REQ-031 During reset, o_ready SHALL be all 0.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, LOCK) and the default DW and N constants.
REQ-033 One sub-module, rr_pick, SHALL hold the combinational round-robin picker with inputs req[N] and ptr[SW] and outputs gnt_idx[SW] and gnt_any.
REQ-034 All remaining logic (FSM, ptr, output register) SHALL be in stream_rr_arbiter.

Verification
REQ-035 Reset, then i_valid=4'b0101, all i_last=1, i_ready=1 -> o_src sequence 0,2,0,2 on consecutive cycles, with o_valid=1 from cycle 1.
REQ-036 Requester 1 sends a 3-beat packet 0x11,0x12,0x13 (last on 0x13) while requester 3 is valid -> output 0x11,0x12,0x13 with o_src=1, then requester 3's beat with o_src=3; no interleave.
REQ-037 i_ready=0 for 3 cycles with o_valid=1, o_data=0xA5 -> o_data stays 0xA5, o_ready=0; the first cycle after i_ready=1 accepts the next beat.
REQ-038 Owner 2 drops i_valid for 2 cycles mid-packet while requester 0 is valid -> o_valid=0 for 2 cycles, o_ready[0] stays 0, and the packet resumes from requester 2.
REQ-039 i_reset_n=0 asserted during beat 2 of a 4-beat packet -> next cycle o_valid=0 and state IDLE; after release, requester 0 wins when all requesters are valid.
REQ-040 All four requesters continuously valid with single-beat packets -> grant order 0,1,2,3,0 and each o_src appears once per 4 beats.
